// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store memory access unit:
//   - state_e           : 2-bit FSM encoding (IDLE, READ, WRITE, RESP)
//   - MEM_WORDS_DEFAULT : default number of addressable 16-bit words
//   - ERR_CNT_W         : width of the saturating error counter
//   - sat_inc()         : saturating increment used by the error counter
// -----------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int unsigned MEM_WORDS_DEFAULT = 128;
    localparam int unsigned ERR_CNT_W         = 8;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage : mem_access_pkg

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Single-outstanding load/store unit sitting between a pipeline and a simple
// single-port data memory. One request is accepted in IDLE, issued to memory
// for one cycle (READ or WRITE), and answered in RESP, which holds until the
// consumer takes the response. Out-of-range addresses skip the memory and are
// answered immediately with an error flag; a saturating counter tracks them.
//
// Ports
//   clk            : system clock, rising edge
//   rst            : asynchronous active-low reset
//   req_valid      : request offered by the pipeline
//   req_ready      : unit can accept a request (IDLE only)
//   req_we         : 1 = store, 0 = load
//   req_addr       : word address (compared unsigned, full width)
//   req_wdata      : store data
//   resp_valid     : response available (RESP only)
//   resp_ready     : consumer takes the response
//   resp_rdata     : load data (0 for stores and errors)
//   resp_err       : request address was out of range
//   mem_read_rq    : one-cycle memory read strobe
//   mem_write_rq   : one-cycle memory write strobe
//   mem_rw_address : memory address, 0 when no access is issued
//   mem_write_data : memory write data, 0 outside a write
//   mem_read_data  : combinational read data returned by the memory
//   err_count      : saturating count of out-of-range requests
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned DATA_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DATA_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,

    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,

    output logic                 mem_read_rq,
    output logic                 mem_write_rq,
    output logic [DATA_W-1:0]    mem_rw_address,
    output logic [DATA_W-1:0]    mem_write_data,
    input  logic [DATA_W-1:0]    mem_read_data,

    output logic [ERR_CNT_W-1:0] err_count
);

    // One extra bit so a MEM_WORDS equal to 2**DATA_W is still representable
    // and the comparison never truncates the incoming address.
    localparam logic [DATA_W:0] MEM_LIMIT = (DATA_W+1)'(MEM_WORDS);

    state_e                 state_q, state_d;
    logic                   we_q,    we_d;
    logic [DATA_W-1:0]      addr_q,  addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   err_q,   err_d;
    logic [ERR_CNT_W-1:0]   errcnt_q, errcnt_d;

    logic                   addr_oob;

    assign addr_oob = ({1'b0, req_addr} >= MEM_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        errcnt_d       = errcnt_q;

        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_read_rq    = 1'b0;
        mem_write_rq   = 1'b0;
        mem_rw_address = '0;
        mem_write_data = '0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (addr_oob) begin
                        // Error responses bypass memory entirely.
                        state_d  = RESP;
                        rdata_d  = '0;
                        err_d    = 1'b1;
                        errcnt_d = sat_inc(errcnt_q);
                    end else if (req_we) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                mem_read_rq    = 1'b1;
                mem_rw_address = addr_q;
                // Memory read data is combinational; capture it on exit.
                rdata_d        = mem_read_data;
                err_d          = 1'b0;
                state_d        = RESP;
            end

            WRITE: begin
                mem_write_rq   = 1'b1;
                mem_rw_address = addr_q;
                mem_write_data = wdata_q;
                rdata_d        = '0;
                err_d          = 1'b0;
                state_d        = RESP;
            end

            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign err_count  = errcnt_q;

endmodule : mem_access_unit

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 128, the number of valid 16-bit words in the data memory.
REQ-002 SHALL have parameter DATA_W, default 16, the data and address width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, the pipeline offers a load/store.
REQ-006 SHALL have port req_ready, output, 1, the unit accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have ports req_addr and req_wdata, input, 16 each: word address and store data.
REQ-009 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_rdata (output, 16) and resp_err (output, 1): the response channel.
REQ-010 SHALL have ports mem_read_rq and mem_write_rq, output, 1 each, driving the data memory read/write requests.
REQ-011 SHALL have ports mem_rw_address and mem_write_data, output, 16 each, and mem_read_data, input, 16, from the data memory.
REQ-012 SHALL have port err_count, output, 8: saturating count of out-of-range requests.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-014 SHALL drive req_ready=1 only in IDLE; a transfer occurs when req_valid && req_ready at a rising edge.
REQ-015 SHALL latch req_we, req_addr and req_wdata on transfer and hold them until the FSM returns to IDLE.
REQ-016 SHALL treat a transfer with req_addr >= MEM_WORDS as an error: IDLE->RESP with resp_err=1 and resp_rdata=0, no memory request, err_count+1 saturating at 255.
REQ-017 SHALL take an in-range store IDLE->WRITE and an in-range load IDLE->READ.
REQ-018 SHALL assert mem_write_rq=1 and mem_read_rq=0 in WRITE for exactly one cycle, then go to RESP with resp_rdata=0 and resp_err=0; the memory commits at the WRITE->RESP edge.
REQ-019 SHALL assert mem_read_rq=1 and mem_write_rq=0 in READ for exactly one cycle, register mem_read_data into resp_rdata at the READ->RESP edge, then go to RESP with resp_err=0.
REQ-020 SHALL never assert mem_read_rq and mem_write_rq together; both SHALL be 0 in IDLE and RESP.
REQ-021 SHALL drive mem_rw_address with the latched address in READ and WRITE, and 0 otherwise.
REQ-022 SHALL drive mem_write_data with the latched data in WRITE only, and 0 otherwise.
REQ-023 SHALL assert resp_valid=1 in RESP, holding resp_rdata and resp_err stable until resp_ready=1, then go RESP->IDLE.
REQ-024 SHALL give an in-range access a latency of 2: transfer at edge N, resp_valid high in the cycle after edge N+1. An error access SHALL have a latency of 1.
REQ-025 SHALL provide no bypass: a request is accepted no earlier than the cycle after RESP exits, so maximum throughput is one access per 3 cycles.
REQ-026 SHALL ignore req_valid while not in IDLE, with no side effects.
REQ-027 SHALL treat resp_ready=1 outside RESP as a don't-care.
REQ-028 SHALL compare addresses unsigned and at full 16 bits, with no truncation: 0x0080 is an error and 0xFFFF is an error.

Reset
REQ-029 SHALL, while rst=0, force IDLE immediately (asynchronously), regardless of the current state.
REQ-030 SHALL, while rst=0, force all outputs except req_ready, all latched fields and err_count to 0; req_ready SHALL read 1 as soon as rst releases.
REQ-031 SHALL discard any access in flight when rst asserts mid-operation; no response is produced.
REQ-032 SHALL leave the memory contents after a reset during WRITE to the memory's own reset.

Structure
REQ-033 SHALL place the FSM state encoding (2-bit) and the MEM_WORDS default in shared package mem_access_pkg.
REQ-034 SHALL need no sub-module; the FSM, range check and counter SHALL be inline, with the memory instantiated alongside by the parent.

Verification
REQ-035 Store then load: store addr 5, data 0xBEEF; then load addr 5 -> mem_write_rq for one cycle, then resp_rdata=0xBEEF, resp_err=0, 2 cycles after acceptance.
REQ-036 Out-of-range: load addr 0x0080 -> resp_valid 1 cycle after acceptance, resp_err=1, resp_rdata=0, no mem_*_rq pulse, err_count=1.
REQ-037 Backpressure: load addr 3 (holding 0x1234) with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata=0x1234 stable throughout, req_ready=0, a concurrent req_valid is ignored.
REQ-038 Saturation: 300 out-of-range requests -> err_count stops at 255.
REQ-039 Reset mid-access: rst low during WRITE -> all outputs 0 at once, no resp_valid; after release req_ready=1 and a new load of addr 0 returns 0.
REQ-040 Exclusivity: random 1000 ops -> mem_read_rq && mem_write_rq never both 1, and each rq pulse is exactly 1 cycle.
